// File: rtl/rv32i_decode_pkg.sv
// Shared types and constants for the RV32I decode stage: opcode map,
// instruction-class and immediate-format enums, and the decoded bundle.
package rv32i_decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    IT_NONE   = 4'd0,
    IT_LOAD   = 4'd1,
    IT_OP_IMM = 4'd2,
    IT_OP     = 4'd3,
    IT_STORE  = 4'd4,
    IT_BRANCH = 4'd5,
    IT_LUI    = 4'd6,
    IT_AUIPC  = 4'd7,
    IT_JAL    = 4'd8,
    IT_JALR   = 4'd9,
    IT_FENCE  = 4'd10,
    IT_SYSTEM = 4'd11
  } inst_type_e;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd7
  } imm_type_e;

  typedef struct packed {
    inst_type_e inst_type;
    imm_type_e  imm_type;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] func3;
    logic [6:0] func7;
  } dec_bundle_t;

  // Default bundle: every field zero, no immediate, opcode kept for visibility.
  function automatic dec_bundle_t dec_default(input logic [6:0] opc);
    dec_bundle_t d;
    d           = '0;
    d.inst_type = IT_NONE;
    d.imm_type  = IMM_NONE;
    d.opcode    = opc;
    return d;
  endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate generator: builds the I/S/B/U/J immediate
// and sign-extends it to XLEN. Only instr[31:7] carries immediate bits.
module rv32i_imm_gen
  import rv32i_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     i_instr,
  input  imm_type_e       i_imm_type,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;

  // Assemble the 32-bit sign-extended immediate for the selected format.
  always_comb begin
    w_imm32 = '0;
    case (i_imm_type)
      IMM_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U: w_imm32 = {i_instr[31:12], 12'b0};
      IMM_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                        i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Widen to XLEN; every format (including U) extends from bit 31.
  always_comb begin
    o_imm        = {XLEN{w_imm32[31]}};
    o_imm[31:0]  = w_imm32;
  end

endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake and flush.
// Optional illegal-instruction detection: define RV32I_DECODE_ILLEGAL_EN.
module rv32i_decode_stage
  import rv32i_decode_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_PASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      inst_type,
  output logic [2:0]      imm_type,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [XLEN-1:0] immediate,
  output logic [XLEN-1:0] out_pc,
  output logic            illegal
);

  logic [6:0]      w_op;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_accept;
  dec_bundle_t     w_dec;
  logic [XLEN-1:0] w_imm;

  logic            r_valid;
  dec_bundle_t     r_dec;
  logic [XLEN-1:0] r_imm;

  assign w_op  = in_instr[6:0];
  assign w_rd  = in_instr[11:7];
  assign w_f3  = in_instr[14:12];
  assign w_rs1 = in_instr[19:15];
  assign w_rs2 = in_instr[24:20];
  assign w_f7  = in_instr[31:25];

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  // Per-opcode field decode; unused fields stay at their zero defaults.
  always_comb begin
    w_dec = dec_default(w_op);
    case (w_op)
      OPC_LOAD: begin
        w_dec.inst_type = IT_LOAD;
        w_dec.imm_type  = IMM_I;
        w_dec.rd        = w_rd;
        w_dec.rs1       = w_rs1;
        w_dec.func3     = w_f3;
      end
      OPC_OP_IMM: begin
        w_dec.inst_type = IT_OP_IMM;
        w_dec.imm_type  = IMM_I;
        w_dec.rd        = w_rd;
        w_dec.rs1       = w_rs1;
        w_dec.func3     = w_f3;
        if (w_f3 == 3'b001 || w_f3 == 3'b101) w_dec.func7 = w_f7;
      end
      OPC_OP: begin
        w_dec.inst_type = IT_OP;
        w_dec.rd        = w_rd;
        w_dec.rs1       = w_rs1;
        w_dec.rs2       = w_rs2;
        w_dec.func3     = w_f3;
        w_dec.func7     = w_f7;
      end
      OPC_STORE: begin
        w_dec.inst_type = IT_STORE;
        w_dec.imm_type  = IMM_S;
        w_dec.rs1       = w_rs1;
        w_dec.rs2       = w_rs2;
        w_dec.func3     = w_f3;
      end
      OPC_BRANCH: begin
        w_dec.inst_type = IT_BRANCH;
        w_dec.imm_type  = IMM_B;
        w_dec.rs1       = w_rs1;
        w_dec.rs2       = w_rs2;
        w_dec.func3     = w_f3;
      end
      OPC_LUI: begin
        w_dec.inst_type = IT_LUI;
        w_dec.imm_type  = IMM_U;
        w_dec.rd        = w_rd;
      end
      OPC_AUIPC: begin
        w_dec.inst_type = IT_AUIPC;
        w_dec.imm_type  = IMM_U;
        w_dec.rd        = w_rd;
      end
      OPC_JAL: begin
        w_dec.inst_type = IT_JAL;
        w_dec.imm_type  = IMM_J;
        w_dec.rd        = w_rd;
      end
      OPC_JALR: begin
        w_dec.inst_type = IT_JALR;
        w_dec.imm_type  = IMM_I;
        w_dec.rd        = w_rd;
        w_dec.rs1       = w_rs1;
        w_dec.func3     = w_f3;
      end
      OPC_FENCE: begin
        w_dec.inst_type = IT_FENCE;
        w_dec.imm_type  = IMM_I;
        w_dec.rd        = w_rd;
        w_dec.rs1       = w_rs1;
        w_dec.func3     = w_f3;
      end
      OPC_SYSTEM: begin
        w_dec.inst_type = IT_SYSTEM;
        w_dec.imm_type  = IMM_I;
        w_dec.rd        = w_rd;
        w_dec.rs1       = w_rs1;
        w_dec.func3     = w_f3;
      end
      default: ;
    endcase
  end

  rv32i_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .i_instr    (in_instr[31:7]),
    .i_imm_type (w_dec.imm_type),
    .o_imm      (w_imm)
  );

  // Output valid: reset beats flush, flush beats accept, drain clears.
  always_ff @(posedge clk) begin
    if (!rst)          r_valid <= 1'b0;
    else if (flush)    r_valid <= 1'b0;
    else if (w_accept) r_valid <= 1'b1;
    else if (out_ready) r_valid <= 1'b0;
  end

  // Decoded data registers load only on an accepted beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dec <= dec_default('0);
      r_imm <= '0;
    end else if (w_accept) begin
      r_dec <= w_dec;
      r_imm <= w_imm;
    end
  end

  generate
    if (PC_PASS != 0) begin : g_pc
      logic [XLEN-1:0] r_pc;
      // PC travels with the beat.
      always_ff @(posedge clk) begin
        if (!rst)          r_pc <= '0;
        else if (w_accept) r_pc <= in_pc;
      end
      assign out_pc = r_pc;
    end else begin : g_no_pc
      assign out_pc = '0;
    end
  endgenerate

`ifdef RV32I_DECODE_ILLEGAL_EN
  logic w_illegal;
  logic r_illegal;

  // Flag reserved encodings of the RV32I base set.
  always_comb begin
    w_illegal = 1'b0;
    case (w_op)
      OPC_LOAD:   w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      OPC_STORE:  w_illegal = (w_f3 > 3'b010);
      OPC_BRANCH: w_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      OPC_JALR:   w_illegal = (w_f3 != 3'b000);
      OPC_OP: begin
        if (w_f7 == F7_BASE)     w_illegal = 1'b0;
        else if (w_f7 == F7_ALT) w_illegal = !((w_f3 == 3'b000) || (w_f3 == 3'b101));
        else                     w_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        if (w_f3 == 3'b001)      w_illegal = (w_f7 != F7_BASE);
        else if (w_f3 == 3'b101) w_illegal = !((w_f7 == F7_BASE) || (w_f7 == F7_ALT));
        else                     w_illegal = 1'b0;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE, OPC_SYSTEM: w_illegal = 1'b0;
      default:    w_illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) w_illegal = 1'b1;
  end

  // Illegal flag is registered alongside the beat it describes.
  always_ff @(posedge clk) begin
    if (!rst)          r_illegal <= 1'b0;
    else if (w_accept) r_illegal <= w_illegal;
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  assign out_valid = r_valid;
  assign inst_type = r_dec.inst_type;
  assign imm_type  = r_dec.imm_type;
  assign opcode    = r_dec.opcode;
  assign rd        = r_dec.rd;
  assign rs1       = r_dec.rs1;
  assign rs2       = r_dec.rs2;
  assign func3     = r_dec.func3;
  assign func7     = r_dec.func7;
  assign immediate = r_imm;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Scoreboard bench for rv32i_decode_stage: XLEN=32 with PC pass-through and
// XLEN=64 without, driven in lockstep by directed hand-decoded instructions.
module tb_rv32i_decode_stage;

  logic        clk;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [63:0] in_pc64;

  logic        in_ready, out_valid, illegal;
  logic [3:0]  inst_type;
  logic [2:0]  imm_type, func3;
  logic [6:0]  opcode, func7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] immediate, out_pc;

  logic        in_ready64, out_valid64, illegal64;
  logic [3:0]  inst_type64;
  logic [2:0]  imm_type64, func3_64;
  logic [6:0]  opcode64, func7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [63:0] immediate64, out_pc64;

  rv32i_decode_stage #(.XLEN(32), .PC_PASS(1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .inst_type(inst_type), .imm_type(imm_type), .opcode(opcode), .rd(rd), .rs1(rs1),
    .rs2(rs2), .func3(func3), .func7(func7), .immediate(immediate), .out_pc(out_pc),
    .illegal(illegal)
  );

  rv32i_decode_stage #(.XLEN(64), .PC_PASS(0)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(out_valid64), .out_ready(out_ready),
    .inst_type(inst_type64), .imm_type(imm_type64), .opcode(opcode64), .rd(rd64),
    .rs1(rs1_64), .rs2(rs2_64), .func3(func3_64), .func7(func7_64),
    .immediate(immediate64), .out_pc(out_pc64), .illegal(illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  it;
    logic [2:0]  imt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          n_pass = 0, n_chk = 0;
  int          n_pushed = 0, n_popped = 0;
  int          cyc = 0;
  logic [31:0] pc_next = 32'h0000_1000;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a beat is consumed on the edge following a negedge where it is
  // presented with out_ready high.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: got instr with opcode 0x%0h, expected no beat", opcode);
      end else begin
        e = q.pop_front();
        n_popped++;
        chk("inst_type", 64'(inst_type), 64'(e.it));
        chk("imm_type",  64'(imm_type),  64'(e.imt));
        chk("opcode",    64'(opcode),    64'(e.instr[6:0]));
        chk("rd",        64'(rd),        64'(e.rd));
        chk("rs1",       64'(rs1),       64'(e.rs1));
        chk("rs2",       64'(rs2),       64'(e.rs2));
        chk("func3",     64'(func3),     64'(e.f3));
        chk("func7",     64'(func7),     64'(e.f7));
        chk("immediate", 64'(immediate), 64'(e.imm));
        chk("out_pc",    64'(out_pc),    64'(e.pc));
        chk("illegal",   64'(illegal),   64'(e.ill));
        chk("valid64",     64'(out_valid64), 64'd1);
        chk("inst_type64", 64'(inst_type64), 64'(e.it));
        chk("rd64",        64'(rd64),        64'(e.rd));
        chk("immediate64", immediate64,      {{32{e.imm[31]}}, e.imm});
        chk("out_pc64",    out_pc64,         64'd0);
        chk("illegal64",   64'(illegal64),   64'(e.ill));
      end
    end
  end

  // Offer one beat; the expected decode is queued once the handshake is seen.
  task automatic send(input logic [31:0] instr, input logic [3:0] it, input logic [2:0] imt,
                      input logic [4:0] rd_e, input logic [4:0] rs1_e, input logic [4:0] rs2_e,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                      input logic ill);
    exp_t e;
    bit   done;
    e.instr = instr; e.pc = pc_next; e.it = it; e.imt = imt;
    e.rd = rd_e; e.rs1 = rs1_e; e.rs2 = rs2_e; e.f3 = f3; e.f7 = f7; e.imm = imm;
`ifdef RV32I_DECODE_ILLEGAL_EN
    e.ill = ill;
`else
    e.ill = 1'b0 & ill;
`endif
    in_instr = instr;
    in_pc    = pc_next;
    in_pc64  = {32'hA5A5_A5A5, pc_next};
    in_valid = 1'b1;
    done     = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1 && flush === 1'b0 && rst === 1'b1) begin
        q.push_back(e);
        n_pushed++;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_chk++;
      $display("FAIL accept_timeout: got no accept of 0x%08h, expected accept within 20 cycles", instr);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    pc_next  = pc_next + 32'd4;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t0;

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_pc64 = '0;
    idle(2);

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm_type",  64'(imm_type),  64'd7);
    chk("rst_inst_type", 64'(inst_type), 64'd0);
    chk("rst_opcode",    64'(opcode),    64'd0);
    chk("rst_immediate", 64'(immediate), 64'd0);
    chk("rst_out_pc",    64'(out_pc),    64'd0);
    chk("rst_illegal",   64'(illegal),   64'd0);
    chk("rst_imm_type64", 64'(imm_type64), 64'd7);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    rst = 1'b1;

    // Full-throughput stream of directed vectors
    t0 = cyc;
    //    instr         it     imt   rd  rs1 rs2 f3  f7     imm           ill
    send(32'hFFC12083, 4'd1,  3'd0, 1, 2, 0, 2, 7'h00, 32'hFFFFFFFC, 0); // lw x1,-4(x2)
    send(32'hFE000EE3, 4'd5,  3'd2, 0, 0, 0, 0, 7'h00, 32'hFFFFFFFC, 0); // beq x0,x0,-4
    send(32'h800000EF, 4'd8,  3'd4, 1, 0, 0, 0, 7'h00, 32'hFFF00000, 0); // jal
    send(32'h800000B7, 4'd6,  3'd3, 1, 0, 0, 0, 7'h00, 32'h80000000, 0); // lui
    send(32'h002081B3, 4'd3,  3'd7, 3, 1, 2, 0, 7'h00, 32'h00000000, 0); // add
    send(32'h40208133, 4'd3,  3'd7, 2, 1, 2, 0, 7'h20, 32'h00000000, 0); // sub
    send(32'h00532423, 4'd4,  3'd1, 0, 6, 5, 2, 7'h00, 32'h00000008, 0); // sw
    send(32'h40315093, 4'd2,  3'd0, 1, 2, 0, 5, 7'h20, 32'h00000403, 0); // srai
    send(32'hFFF00093, 4'd2,  3'd0, 1, 0, 0, 0, 7'h00, 32'hFFFFFFFF, 0); // addi -1
    send(32'h12345297, 4'd7,  3'd3, 5, 0, 0, 0, 7'h00, 32'h12345000, 0); // auipc
    send(32'hFFC080E7, 4'd9,  3'd0, 1, 1, 0, 0, 7'h00, 32'hFFFFFFFC, 0); // jalr
    send(32'h00000073, 4'd11, 3'd0, 0, 0, 0, 0, 7'h00, 32'h00000000, 0); // ecall
    send(32'h0FF0000F, 4'd10, 3'd0, 0, 0, 0, 0, 7'h00, 32'h000000FF, 0); // fence
    send(32'h00003003, 4'd1,  3'd0, 0, 0, 0, 3, 7'h00, 32'h00000000, 1); // load f3=011
    send(32'hFFFFFFFF, 4'd0,  3'd7, 0, 0, 0, 0, 7'h00, 32'h00000000, 1); // unknown
    chk("throughput_cycles", 64'(cyc - t0), 64'd15);
    idle(2);

    // Back-pressure: hold SUB while LW waits
    out_ready = 1'b0;
    send(32'h40208133, 4'd3, 3'd7, 2, 1, 2, 0, 7'h20, 32'h0, 0);
    in_instr = 32'hFFC12083; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready",  64'(in_ready),  64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_rd",        64'(rd),        64'd2);
      chk("bp_func7",     64'(func7),     64'h20);
      chk("bp_inst_type", 64'(inst_type), 64'd3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'hFFC12083, 4'd1, 3'd0, 1, 2, 0, 2, 7'h00, 32'hFFFFFFFC, 0);
    send(32'h00532423, 4'd4, 3'd1, 0, 6, 5, 2, 7'h00, 32'h00000008, 0);
    idle(2);

    // Flush with a held beat and a new beat offered
    out_ready = 1'b0;
    send(32'h800000EF, 4'd8, 3'd4, 1, 0, 0, 0, 7'h00, 32'hFFF00000, 0);
    void'(q.pop_back());
    n_pushed--;
    in_instr = 32'h002081B3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(3);

    // Flush on an empty stage: in_ready stays high, beat dropped
    in_instr = 32'h800000B7; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("flush2_out_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    idle(2);

    // Reset while a beat is stalled
    out_ready = 1'b0;
    send(32'h12345297, 4'd7, 3'd3, 5, 0, 0, 0, 7'h00, 32'h12345000, 0);
    void'(q.pop_back());
    n_pushed--;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rms_out_valid", 64'(out_valid), 64'd0);
    chk("rms_imm_type",  64'(imm_type),  64'd7);
    chk("rms_inst_type", 64'(inst_type), 64'd0);
    chk("rms_opcode",    64'(opcode),    64'd0);
    chk("rms_rd",        64'(rd),        64'd0);
    chk("rms_immediate", 64'(immediate), 64'd0);
    chk("rms_out_pc",    64'(out_pc),    64'd0);
    chk("rms_valid64",   64'(out_valid64), 64'd0);
    rst = 1'b1; out_ready = 1'b1;

    // Post-reset beat and drain
    send(32'h0FF0000F, 4'd10, 3'd0, 0, 0, 0, 0, 7'h00, 32'h000000FF, 0);
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    idle(3);
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("no_loss_dup", 64'(n_popped), 64'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

endmodule
